aer_sender: RTL and testbench



---
 rtl/aer_sender.sv | 143 ++++++++++++++
 tb/tb_aer_sender.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_sender.sv
// Transmit side of a four-phase AER link: events are queued in a small FIFO
// and sent one at a time with a registered address and request.
module aer_sender #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ev_valid,
  input  logic [ADDR_W-1:0]        ev_addr,
  output logic                     ev_ready,
  output logic [ADDR_W-1:0]        aer_addr,
  output logic                     aer_req,
  input  logic                     aer_ack,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout_err
);

  localparam int               PW      = $clog2(DEPTH);
  localparam logic [PW:0]      FULL    = (PW+1)'(DEPTH);
  localparam logic [15:0]      TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_REQ_HI,
    S_REQ_LO
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_ack_sync;
  logic                w_ack_s;
  logic [ADDR_W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [PW:0]         r_count;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_req, w_req_nxt;
  logic                r_terr, w_terr_nxt;
  logic [15:0]         r_timer, w_timer_nxt;
  logic                w_push, w_pop;

  // ack is asynchronous; only the second synchronizer stage is ever used
  always_ff @(posedge clk) begin
    if (rst) r_ack_sync <= '0;
    else     r_ack_sync <= {r_ack_sync[0], aer_ack};
  end
  assign w_ack_s = r_ack_sync[1];

  assign ev_ready = (r_count != FULL);
  assign w_push   = ev_valid & ev_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= ev_addr;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_req_nxt   = r_req;
    w_terr_nxt  = 1'b0;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_nxt = 1'b0;
        // never start a new event while the previous ack is still seen high
        if ((r_count != '0) && !w_ack_s) begin
          w_addr_nxt  = r_mem[r_rptr];
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_req_nxt   = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = S_REQ_HI;
      end
      S_REQ_HI: begin
        w_req_nxt   = 1'b1;
        w_timer_nxt = r_timer + 16'd1;
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_REQ_LO;
        end else if (r_timer == TO_LAST) begin
          w_req_nxt   = 1'b0;
          w_terr_nxt  = 1'b1;
          w_state_nxt = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        w_req_nxt = 1'b0;
        if (!w_ack_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_terr  <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
      r_terr  <= w_terr_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign aer_addr    = r_addr;
  assign aer_req     = r_req;
  assign timeout_err = r_terr;
  assign fifo_count  = r_count;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);

  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    r_req |=> (!r_req || $stable(r_addr)));
  a_no_overflow: assert property (@(posedge clk) r_count <= FULL);

endmodule

// File: tb/tb_aer_sender.sv
// Bench for aer_sender: queue-based reference model compared every cycle,
// directed scenarios with hand-computed latencies, and a short-timeout instance.
module tb_aer_sender;
  localparam int AW   = 8;
  localparam int DEP  = 4;
  localparam int TO   = 255;
  localparam int TO_S = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ev_valid, ev_ready, aer_req, aer_ack, busy, timeout_err;
  logic [AW-1:0] ev_addr, aer_addr;
  logic [2:0]    fifo_count;

  logic          t_valid, t_ready, t_req, t_ack, t_busy, t_terr;
  logic [AW-1:0] t_addr, t_aer_addr;
  logic [2:0]    t_count;

  aer_sender #(.ADDR_W(AW), .DEPTH(DEP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_addr(ev_addr), .ev_ready(ev_ready),
    .aer_addr(aer_addr), .aer_req(aer_req), .aer_ack(aer_ack), .busy(busy),
    .fifo_count(fifo_count), .timeout_err(timeout_err));

  aer_sender #(.ADDR_W(AW), .DEPTH(DEP), .TIMEOUT(TO_S)) dut_to (
    .clk(clk), .rst(rst), .ev_valid(t_valid), .ev_addr(t_addr), .ev_ready(t_ready),
    .aer_addr(t_aer_addr), .aer_req(t_req), .aer_ack(t_ack), .busy(t_busy),
    .fifo_count(t_count), .timeout_err(t_terr));

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (queue + handshake phase) ----------------
  localparam int P_IDLE = 0, P_SETUP = 1, P_HI = 2, P_LO = 3;
  logic [AW-1:0] mq[$];
  int            mph = P_IDLE, mtmr = 0, cyc = 0;
  logic          m_req = 0, m_terr = 0, m_am = 0, m_as = 0, ack_prev = 0;
  logic [AW-1:0] m_addr = '0;
  int            push_edge = 0, ack_rise_edge = 0;

  always @(posedge clk) begin
    bit            push;
    logic [AW-1:0] pa;
    cyc++;
    push = ev_valid && (mq.size() != DEP);
    pa   = ev_addr;
    if (rst) begin
      mq.delete();
      mph = P_IDLE; mtmr = 0; m_req = 0; m_terr = 0; m_addr = '0; m_am = 0; m_as = 0;
    end else begin
      m_terr = 0;
      case (mph)
        P_IDLE: begin
          m_req = 0;
          if (mq.size() > 0 && !m_as) begin m_addr = mq.pop_front(); mph = P_SETUP; end
        end
        P_SETUP: begin m_req = 1; mtmr = 0; mph = P_HI; end
        P_HI: begin
          if (m_as) begin m_req = 0; mph = P_LO; end
          else if (mtmr == TO - 1) begin m_req = 0; m_terr = 1; mph = P_LO; end
          mtmr++;
        end
        default: if (!m_as) mph = P_IDLE;
      endcase
      if (push) begin mq.push_back(pa); push_edge = cyc; end
      m_as = m_am;
      m_am = aer_ack;
      if (aer_ack && !ack_prev) ack_rise_edge = cyc;
    end
    ack_prev = aer_ack;
  end

  // ---------------- per-cycle compare and observation ----------------
  logic          prev_req = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] emitted[$];
  int            req_rise_edge = 0, req_fall_edge = 0, addr_edge = 0, max_cnt = 0;
  bit            saw_not_ready = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("aer_req", aer_req, m_req);
      chk("aer_addr", aer_addr, m_addr);
      chk("timeout_err", timeout_err, m_terr);
      chk("fifo_count", fifo_count, mq.size());
      chk("ev_ready", ev_ready, mq.size() != DEP);
      chk("busy", busy, (mph != P_IDLE) || (mq.size() != 0));
      if (aer_req && prev_req) chk("addr_stable", aer_addr, prev_addr);
      if (aer_req && !prev_req) begin
        chk("rise_with_ack_s", m_as, 0);
        emitted.push_back(aer_addr);
        req_rise_edge = cyc;
      end
      if (!aer_req && prev_req) req_fall_edge = cyc;
      if (aer_addr != prev_addr) addr_edge = cyc;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (!ev_ready) saw_not_ready = 1;
      prev_req  = aer_req;
      prev_addr = aer_addr;
    end
  end

  // ---------------- receivers ----------------
  int rx_mode = 0, rx_dly = 3, rx_cnt = 0;
  initial begin
    aer_ack = 0;
    forever begin
      if (rx_mode == 2) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #($urandom_range(1, 9));
        aer_ack = aer_req;
      end else begin
        @(negedge clk);
        #1;
        if (rx_mode == 1 && aer_req && !aer_ack) begin
          rx_cnt++;
          if (rx_cnt >= rx_dly) aer_ack = 1;
        end else if (rx_mode != 1 || !aer_req) begin
          aer_ack = 0;
          rx_cnt  = 0;
        end
      end
    end
  end

  bit t_rx_en = 0;
  int t_cnt = 0;
  initial begin
    t_ack = 0;
    forever begin
      @(negedge clk);
      #1;
      if (t_rx_en && t_req) begin
        t_cnt++;
        if (t_cnt >= 3) t_ack = 1;
      end else if (!t_req) begin
        t_ack = 0;
        t_cnt = 0;
      end
    end
  end

  int            t_hi = 0, t_terr_cnt = 0, t_lens[$];
  logic          t_prev = 0;
  logic [AW-1:0] t_emit[$];
  always @(negedge clk) begin
    if (t_req) t_hi++;
    if (t_req && !t_prev) t_emit.push_back(t_aer_addr);
    if (!t_req && t_prev) begin t_lens.push_back(t_hi); t_hi = 0; end
    if (t_terr) begin
      t_terr_cnt++;
      chk("terr_with_req_fall", {t_prev, t_req}, 2'b10);
    end
    t_prev = t_req;
  end

  // ---------------- stimulus helpers ----------------
  logic [AW-1:0] exp_q[$];
  int            em_base = 0;

  task automatic send(input logic [AW-1:0] a);
    int   k = 0;
    logic r;
    ev_valid = 1; ev_addr = a;
    do begin r = ev_ready; @(negedge clk); k++; end while (!r && k < 5000);
    ev_valid = 0;
    if (r) exp_q.push_back(a);
    else chk("send_timeout", 0, 1);
  endtask

  task automatic send_t(input logic [AW-1:0] a);
    int   k = 0;
    logic r;
    t_valid = 1; t_addr = a;
    do begin r = t_ready; @(negedge clk); k++; end while (!r && k < 100);
    t_valid = 0;
    if (!r) chk("send_t_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int k = 0;
    repeat (2) @(negedge clk);
    while ((busy || aer_ack) && k < maxc) begin @(negedge clk); k++; end
    chk(nm, k < maxc, 1);
  endtask

  task automatic check_order(input string nm);
    chk({nm, "_count"}, emitted.size() - em_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && em_base + i < emitted.size(); i++)
      chk(nm, emitted[em_base + i], exp_q[i]);
  endtask

  task automatic start_test;
    exp_q.delete();
    em_base = emitted.size();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; ev_valid = 0; ev_addr = '0; t_valid = 0; t_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", aer_req, 0);
    chk("rst_addr", aer_addr, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", ev_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 0;
    @(negedge clk);

    // single event, receiver answering ~3 cycles after req
    start_test; rx_mode = 1; rx_dly = 3;
    send(8'h5A);
    wait_idle("single_idle", 200);
    chk("single_addr_lat", addr_edge - push_edge, 1);
    chk("single_req_lat", req_rise_edge - push_edge, 2);
    chk("single_ack_to_fall", req_fall_edge - ack_rise_edge, 2);
    chk("single_busy_end", busy, 0);
    check_order("single_order");

    // burst of 6 into a 4-deep FIFO with a slow receiver
    start_test; rx_dly = 10; max_cnt = 0; saw_not_ready = 0;
    for (int i = 1; i <= 6; i++) send(AW'(i));
    wait_idle("burst_idle", 1000);
    chk("burst_not_ready_seen", saw_not_ready, 1);
    chk("burst_max_count", max_cnt, 4);
    check_order("burst_order");

    // 20 events to exercise pointer wrap and concurrent push/pop
    start_test; rx_dly = 2;
    for (int i = 0; i < 20; i++) begin
      send(AW'(8'h30 + i));
      if (i % 5 == 4) repeat (3) @(negedge clk);
    end
    wait_idle("wrap_idle", 2000);
    check_order("wrap_order");

    // reset in the middle of a request that is never acknowledged
    start_test; rx_mode = 0;
    send(8'h77); send(8'h78);
    begin
      int k = 0;
      while (!aer_req && k < 50) begin @(negedge clk); k++; end
      chk("rst_mid_req_seen", aer_req, 1);
    end
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_req", aer_req, 0);
    chk("rst_mid_count", fifo_count, 0);
    chk("rst_mid_ready", ev_ready, 1);
    chk("rst_mid_addr", aer_addr, 0);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    check_order("rst_mid_order");

    // random-phase receiver over 500 events
    start_test; rx_mode = 2;
    for (int i = 0; i < 500; i++) begin
      send(AW'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("rand_idle", 20000);
    check_order("rand_order");
    rx_mode = 0;

    // short-timeout instance: 0x11 is never acked, 0x22 follows normally
    send_t(8'h11); send_t(8'h22);
    begin
      int k = 0;
      while (!t_terr && k < 100) begin @(negedge clk); k++; end
      chk("to_terr_seen", t_terr, 1);
      t_rx_en = 1;
      k = 0;
      while ((t_busy || t_ack) && k < 200) begin @(negedge clk); k++; end
      chk("to_idle", k < 200, 1);
    end
    chk("to_terr_pulses", t_terr_cnt, 1);
    chk("to_events", t_lens.size(), 2);
    if (t_lens.size() > 0) chk("to_req_high_len", t_lens[0], 8);
    chk("to_emit_count", t_emit.size(), 2);
    if (t_emit.size() > 1) begin
      chk("to_emit0", t_emit[0], 8'h11);
      chk("to_emit1", t_emit[1], 8'h22);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
